// File: rtl/command_fetch.sv
// Direct-mapped, read-only command cache: 128 lines x 8 commands, line fills
// from SDRAM as 16 halfword beats, synchronous-read data RAM.
module command_fetch (
  input  logic        clock,
  input  logic        reset,
  input  logic [20:0] command_addr,
  output logic [31:0] next_command,
  output logic        enabled,
  input  logic        invalidate,
  output logic        fill_req,
  output logic [21:0] fill_addr,
  input  logic        fill_ack,
  input  logic [15:0] fill_data,
  input  logic        fill_valid
);

  typedef enum logic [2:0] {
    LOOKUP   = 3'd0,
    FILL_REQ = 3'd1,
    FILL     = 3'd2,
    REPLAY   = 3'd3,
    DRAIN    = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [20:0] a_q;
  logic [127:0] valid;
  logic [10:0] tags [0:127];
  logic [31:0] mem  [0:1023];
  logic [3:0]  beat;
  logic [3:0]  drain_count;
  logic [15:0] low_half;
  logic        inv_seen;
  logic        hit;
  logic        line_done;
  logic        ram_write;
  logic [9:0]  rd_addr;
  logic [6:0]  index;

  assign index = a_q[9:3];

  always_comb begin
    hit       = valid[index] && (tags[index] == a_q[20:10]);
    enabled   = (state == LOOKUP) && hit && !invalidate && !reset;
    fill_req  = (state == FILL_REQ) && !reset;
    fill_addr = {a_q[20:3], 4'b0000};
    line_done = (state == FILL) && fill_valid && (beat == 4'd15) && !reset;
    ram_write = (state == FILL) && fill_valid && beat[0] && !reset;
    rd_addr   = (state == LOOKUP) ? command_addr[9:0] : a_q[9:0];
  end

  // A reset that lands mid-burst must still swallow the rest of the burst,
  // so FILL and DRAIN survive reset as DRAIN until the 16th beat is seen.
  always_comb begin
    state_next = state;
    if (reset) begin
      if ((state == FILL) && !(fill_valid && (beat == 4'd15)))
        state_next = DRAIN;
      else if ((state == DRAIN) && !(fill_valid && (drain_count == 4'd15)))
        state_next = DRAIN;
      else
        state_next = LOOKUP;
    end else begin
      case (state)
        LOOKUP:   if (!enabled) state_next = FILL_REQ;
                  else          state_next = LOOKUP;
        FILL_REQ: if (fill_ack) state_next = FILL;
                  else          state_next = FILL_REQ;
        FILL:     if (fill_valid && (beat == 4'd15)) state_next = REPLAY;
                  else                               state_next = FILL;
        REPLAY:   state_next = LOOKUP;
        DRAIN:    if (fill_valid && (drain_count == 4'd15)) state_next = LOOKUP;
                  else                                      state_next = DRAIN;
        default:  state_next = LOOKUP;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset)
      a_q <= 21'd0;
    else if (state == LOOKUP)
      a_q <= command_addr;
  end

  always_ff @(posedge clock) begin
    if (reset)
      beat <= 4'd0;
    else if ((state == FILL_REQ) && fill_ack)
      beat <= 4'd0;
    else if ((state == FILL) && fill_valid)
      beat <= beat + 4'd1;
  end

  // Drain count starts from the beats already consumed before reset hit.
  always_ff @(posedge clock) begin
    if (reset && (state == FILL))
      drain_count <= beat + {3'b000, fill_valid};
    else if ((state == DRAIN) && fill_valid)
      drain_count <= drain_count + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset)
      inv_seen <= 1'b0;
    else if (state == LOOKUP)
      inv_seen <= 1'b0;
    else if (invalidate)
      inv_seen <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset || invalidate)
      valid <= 128'd0;
    else if (line_done && !inv_seen)
      valid[index] <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (line_done)
      tags[index] <= a_q[20:10];
  end

  always_ff @(posedge clock) begin
    if ((state == FILL) && fill_valid && !beat[0])
      low_half <= fill_data;
  end

  always_ff @(posedge clock) begin
    if (ram_write)
      mem[{index, beat[3:1]}] <= {fill_data, low_half};
    next_command <= mem[rd_addr];
  end

endmodule

// File: tb/tb_command_fetch.sv
// Directed self-checking bench for command_fetch with a small SDRAM burst driver.
module tb_command_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [20:0] command_addr;
  logic [31:0] next_command;
  logic        enabled;
  logic        invalidate;
  logic        fill_req;
  logic [21:0] fill_addr;
  logic        fill_ack;
  logic [15:0] fill_data;
  logic        fill_valid;

  int checks = 0;
  int errors = 0;

  command_fetch dut (
    .clock(clock), .reset(reset), .command_addr(command_addr),
    .next_command(next_command), .enabled(enabled), .invalidate(invalidate),
    .fill_req(fill_req), .fill_addr(fill_addr), .fill_ack(fill_ack),
    .fill_data(fill_data), .fill_valid(fill_valid)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  function automatic logic [15:0] beat_val(input logic [15:0] seed, input int k);
    logic [31:0] p;
    p = 32'(seed) * 32'(k + 1);
    return p[15:0];
  endfunction

  function automatic logic [31:0] word_val(input logic [15:0] seed, input int w);
    return {beat_val(seed, 2 * w + 1), beat_val(seed, 2 * w)};
  endfunction

  // Returns at a falling edge where fill_req is high, or after 40 cycles.
  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      if (fill_req === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic burst(input logic [15:0] seed, input int n, input int inv_at);
    fill_ack = 1'b1;
    @(negedge clock);
    fill_ack = 1'b0;
    for (int k = 0; k < n; k++) begin
      fill_valid = 1'b1;
      fill_data  = beat_val(seed, k);
      invalidate = (k == inv_at);
      @(negedge clock);
    end
    fill_valid = 1'b0;
    invalidate = 1'b0;
    fill_data  = 16'h0000;
  endtask

  task automatic test_reset;
    reset = 1'b1; invalidate = 1'b0; fill_ack = 1'b0; fill_valid = 1'b0;
    fill_data = 16'h0000; command_addr = 21'd0;
    repeat (3) @(negedge clock);
    checks++; if (enabled !== 1'b0) begin errors++; $display("FAIL reset_enabled got %b exp 0", enabled); end
    checks++; if (fill_req !== 1'b0) begin errors++; $display("FAIL reset_fill_req got %b exp 0", fill_req); end
    reset = 1'b0;
  endtask

  task automatic test_cold_start;
    bit seen;
    wait_req(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL cold_req_seen got %b exp 1", seen); end
    checks++; if (fill_addr !== 22'h000000) begin errors++; $display("FAIL cold_fill_addr got %h exp 000000", fill_addr); end
    checks++; if (enabled !== 1'b0) begin errors++; $display("FAIL cold_stall got %b exp 0", enabled); end
    burst(16'h1111, 16, -1);
    checks++; if (enabled !== 1'b0) begin errors++; $display("FAIL cold_replay got %b exp 0", enabled); end
    @(negedge clock);
    checks++; if (enabled !== 1'b1) begin errors++; $display("FAIL cold_enabled got %b exp 1", enabled); end
    checks++; if (next_command !== 32'h22221111) begin errors++; $display("FAIL cold_data got %h exp 22221111", next_command); end
  endtask

  task automatic test_sequential_hit;
    for (int n = 1; n < 8; n++) begin
      command_addr = 21'(n);
      @(negedge clock);
      checks++; if (enabled !== 1'b1) begin errors++; $display("FAIL seq_enabled[%0d] got %b exp 1", n, enabled); end
      checks++; if (fill_req !== 1'b0) begin errors++; $display("FAIL seq_fill_req[%0d] got %b exp 0", n, fill_req); end
      checks++; if (next_command !== word_val(16'h1111, n)) begin errors++; $display("FAIL seq_data[%0d] got %h exp %h", n, next_command, word_val(16'h1111, n)); end
    end
  endtask

  task automatic test_line_crossing;
    bit seen;
    command_addr = 21'h000008;
    @(negedge clock);
    checks++; if (enabled !== 1'b0) begin errors++; $display("FAIL cross_stall got %b exp 0", enabled); end
    wait_req(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL cross_req_seen got %b exp 1", seen); end
    checks++; if (fill_addr !== 22'h000010) begin errors++; $display("FAIL cross_fill_addr got %h exp 000010", fill_addr); end
    burst(16'h0303, 16, -1);
    checks++; if (enabled !== 1'b0) begin errors++; $display("FAIL cross_replay got %b exp 0", enabled); end
    @(negedge clock);
    checks++; if (enabled !== 1'b1) begin errors++; $display("FAIL cross_enabled got %b exp 1", enabled); end
    checks++; if (next_command !== word_val(16'h0303, 0)) begin errors++; $display("FAIL cross_data got %h exp %h", next_command, word_val(16'h0303, 0)); end
  endtask

  task automatic test_conflict;
    bit seen;
    command_addr = 21'h000408;
    @(negedge clock);
    checks++; if (enabled !== 1'b0) begin errors++; $display("FAIL conf_miss1 got %b exp 0", enabled); end
    wait_req(seen);
    checks++; if (fill_addr !== 22'h000810) begin errors++; $display("FAIL conf_fill_addr1 got %h exp 000810", fill_addr); end
    burst(16'h0505, 16, -1);
    @(negedge clock);
    checks++; if (enabled !== 1'b1) begin errors++; $display("FAIL conf_hit1 got %b exp 1", enabled); end
    checks++; if (next_command !== word_val(16'h0505, 0)) begin errors++; $display("FAIL conf_data1 got %h exp %h", next_command, word_val(16'h0505, 0)); end
    command_addr = 21'h000008;
    @(negedge clock);
    checks++; if (enabled !== 1'b0) begin errors++; $display("FAIL conf_miss2 got %b exp 0", enabled); end
    wait_req(seen);
    checks++; if (fill_addr !== 22'h000010) begin errors++; $display("FAIL conf_fill_addr2 got %h exp 000010", fill_addr); end
    burst(16'h0707, 16, -1);
    @(negedge clock);
    checks++; if (enabled !== 1'b1) begin errors++; $display("FAIL conf_hit2 got %b exp 1", enabled); end
    checks++; if (next_command !== word_val(16'h0707, 0)) begin errors++; $display("FAIL conf_data2 got %h exp %h", next_command, word_val(16'h0707, 0)); end
  endtask

  task automatic test_invalidate_lookup;
    command_addr = 21'h000009;
    @(negedge clock);
    checks++; if (enabled !== 1'b1) begin errors++; $display("FAIL invl_hit got %b exp 1", enabled); end
    checks++; if (next_command !== word_val(16'h0707, 1)) begin errors++; $display("FAIL invl_data got %h exp %h", next_command, word_val(16'h0707, 1)); end
    invalidate = 1'b1;
    #1;
    checks++; if (enabled !== 1'b0) begin errors++; $display("FAIL invl_forced_low got %b exp 0", enabled); end
    @(negedge clock);
    invalidate = 1'b0;
    checks++; if (fill_req !== 1'b1) begin errors++; $display("FAIL invl_fill_req got %b exp 1", fill_req); end
    checks++; if (fill_addr !== 22'h000010) begin errors++; $display("FAIL invl_fill_addr got %h exp 000010", fill_addr); end
    burst(16'h0909, 16, -1);
    @(negedge clock);
    checks++; if (enabled !== 1'b1) begin errors++; $display("FAIL invl_refill_hit got %b exp 1", enabled); end
    checks++; if (next_command !== word_val(16'h0909, 1)) begin errors++; $display("FAIL invl_refill_data got %h exp %h", next_command, word_val(16'h0909, 1)); end
  endtask

  task automatic test_invalidate_mid_fill;
    bit seen;
    command_addr = 21'h000020;
    @(negedge clock);
    wait_req(seen);
    checks++; if (fill_addr !== 22'h000040) begin errors++; $display("FAIL invf_fill_addr1 got %h exp 000040", fill_addr); end
    burst(16'h0b0b, 16, 5);
    checks++; if (enabled !== 1'b0) begin errors++; $display("FAIL invf_replay got %b exp 0", enabled); end
    @(negedge clock);
    checks++; if (enabled !== 1'b0) begin errors++; $display("FAIL invf_remiss got %b exp 0", enabled); end
    wait_req(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL invf_req2_seen got %b exp 1", seen); end
    checks++; if (fill_addr !== 22'h000040) begin errors++; $display("FAIL invf_fill_addr2 got %h exp 000040", fill_addr); end
    checks++; if (enabled !== 1'b0) begin errors++; $display("FAIL invf_stall2 got %b exp 0", enabled); end
    burst(16'h0c0c, 16, -1);
    @(negedge clock);
    checks++; if (enabled !== 1'b1) begin errors++; $display("FAIL invf_hit got %b exp 1", enabled); end
    checks++; if (next_command !== word_val(16'h0c0c, 0)) begin errors++; $display("FAIL invf_data got %h exp %h", next_command, word_val(16'h0c0c, 0)); end
  endtask

  task automatic test_reset_mid_fill;
    bit seen;
    command_addr = 21'h000030;
    @(negedge clock);
    wait_req(seen);
    checks++; if (fill_addr !== 22'h000060) begin errors++; $display("FAIL rst_fill_addr1 got %h exp 000060", fill_addr); end
    burst(16'h0d0d, 9, -1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      fill_valid = 1'b1;
      fill_data  = 16'hdead;
      @(negedge clock);
      checks++; if (fill_req !== 1'b0) begin errors++; $display("FAIL rst_drain_req[%0d] got %b exp 0", k, fill_req); end
      checks++; if (enabled !== 1'b0) begin errors++; $display("FAIL rst_drain_en[%0d] got %b exp 0", k, enabled); end
    end
    fill_valid = 1'b0;
    fill_data  = 16'h0000;
    wait_req(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_req2_seen got %b exp 1", seen); end
    checks++; if (fill_addr !== 22'h000060) begin errors++; $display("FAIL rst_fill_addr2 got %h exp 000060", fill_addr); end
    burst(16'h0e0e, 16, -1);
    @(negedge clock);
    checks++; if (enabled !== 1'b1) begin errors++; $display("FAIL rst_refill_hit got %b exp 1", enabled); end
    checks++; if (next_command !== word_val(16'h0e0e, 0)) begin errors++; $display("FAIL rst_refill_data got %h exp %h", next_command, word_val(16'h0e0e, 0)); end
    command_addr = 21'h000000;
    @(negedge clock);
    checks++; if (enabled !== 1'b0) begin errors++; $display("FAIL rst_line0_miss got %b exp 0", enabled); end
    wait_req(seen);
    checks++; if (fill_addr !== 22'h000000) begin errors++; $display("FAIL rst_fill_addr3 got %h exp 000000", fill_addr); end
    burst(16'h0f0f, 16, -1);
    @(negedge clock);
    checks++; if (next_command !== word_val(16'h0f0f, 0)) begin errors++; $display("FAIL rst_line0_data got %h exp %h", next_command, word_val(16'h0f0f, 0)); end
  endtask

  task automatic test_stray_beats;
    fill_valid = 1'b1;
    fill_data  = 16'hffff;
    for (int i = 1; i <= 20; i++) begin
      command_addr = 21'(i % 8);
      @(negedge clock);
      checks++; if (enabled !== 1'b1) begin errors++; $display("FAIL stray_enabled[%0d] got %b exp 1", i, enabled); end
      checks++; if (next_command !== word_val(16'h0f0f, i % 8)) begin errors++; $display("FAIL stray_data[%0d] got %h exp %h", i, next_command, word_val(16'h0f0f, i % 8)); end
    end
    fill_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_sequential_hit();
    test_line_crossing();
    test_conflict();
    test_invalidate_lookup();
    test_invalidate_mid_fill();
    test_reset_mid_fill();
    test_stray_beats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/command_fetch.md
COMMAND_FETCH -- requirements
Module: command_fetch

Interface
REQ-001 Parameters: none; geometry fixed at 128 lines x 8 commands of 32 bits (1024 commands), direct-mapped.
REQ-002 clock  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 command_addr  in  21  command word address requested by the control unit for the next cycle.
REQ-005 next_command  out  32  command stored at the address captured on the previous enabled edge.
REQ-006 enabled  out  1  high = next_command valid, control unit advances this cycle; low = control unit stalls and holds command_addr stable.
REQ-007 invalidate  in  1  one-cycle pulse; clears all line valid bits.
REQ-008 fill_req  out  1  line fill request to SDRAM controller, held until acknowledged.
REQ-009 fill_addr  out  22  16-bit halfword address of the line, {A_q[20:3], 4'b0}.
REQ-010 fill_ack  in  1  one-cycle acceptance of fill_req.
REQ-011 fill_data  in  16  burst data, low half of each command first.
REQ-012 fill_valid  in  1  fill_data beat strobe; exactly 16 beats per accepted request.

Function
REQ-013 Address split: index = addr[9:3], tag = addr[20:10] (11 bits), word = addr[2:0].
REQ-014 A_q register captures command_addr on every edge where enabled is high or state is LOOKUP.
REQ-015 Data RAM is synchronous-read; read address = command_addr in LOOKUP, A_q in REPLAY.
REQ-016 Tag and valid arrays are registers, read combinationally with A_q.
REQ-017 States: LOOKUP, FILL_REQ, FILL, REPLAY, DRAIN.
REQ-018 LOOKUP: hit = valid[index] && tag match on A_q; enabled = hit; miss -> FILL_REQ next edge.
REQ-019 FILL_REQ: fill_req = 1, fill_addr per REQ-009; on fill_ack -> FILL, beat counter = 0.
REQ-020 FILL: each fill_valid increments 4-bit beat counter; even beat latched as low half, odd beat writes {fill_data, low} to RAM at {index, beat[3:1]}.
REQ-021 After beat 15: tag[index] <= A_q tag, valid[index] <= 1 unless invalidate was seen during this fill; -> REPLAY.
REQ-022 REPLAY: one cycle RAM read of A_q, enabled = 0; -> LOOKUP (hit on next cycle).
REQ-023 Miss latency: fill_ack edge to enabled high = 16 fill_valid beats + 2 cycles.
REQ-024 enabled is 0 in every state except LOOKUP with hit.
REQ-025 invalidate in LOOKUP: all valid bits cleared next edge; enabled forced 0 that cycle; current access re-evaluated as miss.
REQ-026 invalidate in FILL_REQ/FILL/REPLAY: valid bits cleared, in-flight line completes but is not marked valid; REPLAY returns to LOOKUP and re-misses.
REQ-027 fill_valid outside FILL/DRAIN is ignored; more than 16 beats never corrupt RAM.
REQ-028 Line fill into the same index overwrites previous tag (no victim write-back; cache is read-only).

Reset
REQ-029 Reset: state = LOOKUP, all valid bits 0, A_q = 0, fill_req = 0, enabled = 0, beat counter = 0.
REQ-030 Reset asserted during FILL (ack received, beats outstanding): state -> DRAIN after reset; DRAIN discards remaining beats of the burst, no RAM write, then -> LOOKUP.
REQ-031 Reset during FILL_REQ before ack: request withdrawn, state -> LOOKUP, no DRAIN.
REQ-032 next_command content after reset is don't-care while enabled = 0.

Verification
REQ-033 Cold start: reset, command_addr = 0 -> fill_req with fill_addr = 0x000000; after 16 beats (0x1111,0x2222...) enabled high, next_command = 0x22221111.
REQ-034 Sequential hit: addresses 0..7 after fill -> enabled high every cycle, no fill_req, next_command = word n each cycle.
REQ-035 Conflict: fill addr 0x000008, then 0x000408 (same index 1, tag 1) -> second miss, fill_addr = 0x000810; return to 0x000008 misses again.
REQ-036 Line crossing: addr 7 -> 8 with line 1 absent -> enabled low on 8, fill_addr = 0x000010, word 8 delivered after 18 cycles from ack.
REQ-037 Invalidate mid-fill at beat 5 -> fill completes, REPLAY, then second fill_req same address; enabled stays 0 until second fill done.
REQ-038 Reset at beat 9 of fill -> remaining 7 beats drained, no RAM write, all valid 0, next access to same address misses.
